// File: rtl/pc_fetch_sequencer.sv
// Program-counter fetch/branch sequencer: runs T0-T2 fetch, dispatches control-flow
// opcodes, evaluates branch conditions and hands other opcodes to the execute controller.
module pc_fetch_sequencer #(
  parameter int unsigned OPW  = 5,
  parameter int unsigned CNTW = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            run,
  input  logic            mem_ready,
  input  logic [31:0]     ir,
  input  logic [31:0]     bus_in,
  input  logic            exec_done,
  output logic            pc_out,
  output logic            mar_in,
  output logic            inc_pc,
  output logic            mem_read,
  output logic            mdr_in,
  output logic            mdr_out,
  output logic            ir_in,
  output logic            ra_out,
  output logic            link_in,
  output logic            pc_load,
  output logic            con,
  output logic [31:0]     c_sext,
  output logic            exec_start,
  output logic            halted,
  output logic [CNTW-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_DECODE, S_BR_EVAL, S_BR_TAKE,
    S_LINK, S_JUMP, S_EXEC, S_RETIRE, S_HALT
  } state_t;

  localparam logic [OPW-1:0] OP_BR   = OPW'(5'h12);
  localparam logic [OPW-1:0] OP_JR   = OPW'(5'h13);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(5'h14);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'h1A);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'h1B);

  state_t          r_state;
  state_t          w_nxt;
  logic            r_take;
  logic [CNTW-1:0] r_count;
  logic            r_pc_out, r_mar_in, r_inc_pc, r_mem_read, r_mdr_in, r_mdr_out;
  logic            r_ir_in, r_ra_out, r_link_in, r_pc_load, r_con, r_exec_start, r_halted;
  logic [OPW-1:0]  w_opcode;
  logic            w_zero;
  logic            w_cond;
  logic            w_unused;

  assign w_opcode = ir[31 -: OPW];
  assign w_zero   = (bus_in == 32'd0);
  assign w_unused = ^ir[26:21];
  assign c_sext   = {{13{ir[18]}}, ir[18:0]};

  // Branch condition C2 evaluated against the register value on the bus
  always_comb begin
    w_cond = 1'b0;
    case (ir[20:19])
      2'b00:   w_cond = w_zero;
      2'b01:   w_cond = !w_zero;
      2'b10:   w_cond = !bus_in[31] && !w_zero;
      default: w_cond = bus_in[31];
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    if (run) w_nxt = S_T0;
      S_T0:      w_nxt = S_T1;
      S_T1:      if (mem_ready) w_nxt = S_T2;
      S_T2:      w_nxt = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          OP_BR:   w_nxt = S_BR_EVAL;
          OP_JR:   w_nxt = S_JUMP;
          OP_JAL:  w_nxt = S_LINK;
          OP_NOP:  w_nxt = S_RETIRE;
          OP_HALT: w_nxt = S_HALT;
          default: w_nxt = S_EXEC;
        endcase
      end
      S_BR_EVAL: w_nxt = w_cond ? S_BR_TAKE : S_RETIRE;
      S_BR_TAKE: w_nxt = S_RETIRE;
      S_LINK:    w_nxt = S_JUMP;
      S_JUMP:    w_nxt = S_RETIRE;
      S_EXEC:    if (exec_done) w_nxt = S_RETIRE;
      S_RETIRE:  w_nxt = run ? S_T0 : S_IDLE;
      S_HALT:    w_nxt = S_HALT;
      default:   w_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are pure Moore outputs of r_state
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state      <= S_IDLE;
      r_take       <= 1'b0;
      r_count      <= '0;
      r_pc_out     <= 1'b0;
      r_mar_in     <= 1'b0;
      r_inc_pc     <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mdr_in     <= 1'b0;
      r_mdr_out    <= 1'b0;
      r_ir_in      <= 1'b0;
      r_ra_out     <= 1'b0;
      r_link_in    <= 1'b0;
      r_pc_load    <= 1'b0;
      r_con        <= 1'b0;
      r_exec_start <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_pc_out     <= (w_nxt == S_T0) || (w_nxt == S_LINK);
      r_mar_in     <= (w_nxt == S_T0);
      r_inc_pc     <= (w_nxt == S_T0);
      r_mem_read   <= (w_nxt == S_T1);
      r_mdr_in     <= (w_nxt == S_T1);
      r_mdr_out    <= (w_nxt == S_T2);
      r_ir_in      <= (w_nxt == S_T2);
      r_ra_out     <= (w_nxt == S_BR_EVAL) || (w_nxt == S_JUMP);
      r_link_in    <= (w_nxt == S_LINK);
      r_pc_load    <= (w_nxt == S_JUMP);
      r_con        <= (w_nxt == S_BR_TAKE);
      r_exec_start <= (w_nxt == S_EXEC) && (r_state != S_EXEC);
      r_halted     <= (w_nxt == S_HALT);
      if (r_state == S_BR_EVAL) r_take <= w_cond;
      if (r_state == S_RETIRE) r_count <= r_count + CNTW'(1);
    end
  end

  assign pc_out      = r_pc_out;
  assign mar_in      = r_mar_in;
  assign inc_pc      = r_inc_pc;
  assign mem_read    = r_mem_read;
  assign mdr_in      = r_mdr_in;
  assign mdr_out     = r_mdr_out;
  assign ir_in       = r_ir_in;
  assign ra_out      = r_ra_out;
  assign link_in     = r_link_in;
  assign pc_load     = r_pc_load;
  assign con         = r_con;
  assign exec_start  = r_exec_start;
  assign halted      = r_halted;
  assign instr_count = r_count;

  // The PC must never see more than one of its update controls at once
  a_pc_ctrl_excl: assert property (@(posedge clock) disable iff (clear)
    $onehot0({r_pc_load, r_con, r_inc_pc}));
  a_take_latched: assert property (@(posedge clock) disable iff (clear)
    (r_state == S_BR_TAKE) |-> r_take);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: per-instruction expectations are queued at T0
// and compared against strobe counts collected until the retire counter advances.
module tb_pc_fetch_sequencer;
  localparam int unsigned CNTW = 8;
  localparam logic [4:0] OP_BR = 5'h12, OP_JR = 5'h13, OP_JAL = 5'h14;
  localparam logic [4:0] OP_NOP = 5'h1A, OP_HALT = 5'h1B, OP_ADD = 5'h03;

  logic clock = 1'b0;
  logic clear, run;
  logic mem_ready = 1'b0;
  logic exec_done = 1'b0;
  logic [31:0] ir, bus_in, c_sext;
  logic pc_out, mar_in, inc_pc, mem_read, mdr_in, mdr_out, ir_in, ra_out;
  logic link_in, pc_load, con, exec_start, halted;
  logic [CNTW-1:0] instr_count;
  logic [12:0] all_o;

  assign all_o = {pc_out, mar_in, inc_pc, mem_read, mdr_in, mdr_out, ir_in,
                  ra_out, link_in, pc_load, con, exec_start, halted};

  pc_fetch_sequencer #(.OPW(5), .CNTW(CNTW)) dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .bus_in(bus_in), .exec_done(exec_done), .pc_out(pc_out), .mar_in(mar_in),
    .inc_pc(inc_pc), .mem_read(mem_read), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .ir_in(ir_in), .ra_out(ra_out), .link_in(link_in), .pc_load(pc_load),
    .con(con), .c_sext(c_sext), .exec_start(exec_start), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cycles; int mem_rd; int inc_pc; int ir_in; int ra_out;
    int link_in; int pc_load; int con; int exec_start;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;
  int n_chk = 0, n_pass = 0, n_issued = 0;
  int g_stall = 0, g_delay = 0, mcnt = 0, ecnt = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // Memory and execute-controller responders
  always @(negedge clock) begin
    if (mem_read) begin
      if (mcnt >= g_stall) mem_ready = 1'b1;
      else begin mem_ready = 1'b0; mcnt++; end
    end else begin
      mcnt = 0; mem_ready = 1'b0;
    end
    if (exec_start) ecnt = g_delay;
    else if (ecnt > 0) ecnt--;
    else ecnt = -1;
    exec_done = (ecnt == 0);
  end

  // Monitor: collect strobes per instruction window, compare on retire
  bit act = 1'b0;
  int c_cyc, c_mrd, c_inc, c_ir, c_ra, c_lnk, c_pld, c_con, c_es;
  logic [CNTW-1:0] prev_cnt = '0, mdl_cnt = '0;

  always @(negedge clock) begin
    if (clear) begin
      act = 1'b0; prev_cnt = '0; mdl_cnt = '0;
    end else begin
      if (instr_count != prev_cnt) begin
        mdl_cnt = mdl_cnt + CNTW'(1);
        check("instr_count", 32'(instr_count), 32'(mdl_cnt));
        prev_cnt = instr_count;
        if (!act || sb.size() == 0) check("retire_expected", 32'(sb.size()), 32'd1);
        else begin
          e_pop = sb.pop_front();
          check("cycles", c_cyc, e_pop.cycles);
          check("mem_read_cycles", c_mrd, e_pop.mem_rd);
          check("inc_pc_pulses", c_inc, e_pop.inc_pc);
          check("ir_in_pulses", c_ir, e_pop.ir_in);
          check("ra_out_pulses", c_ra, e_pop.ra_out);
          check("link_in_pulses", c_lnk, e_pop.link_in);
          check("pc_load_pulses", c_pld, e_pop.pc_load);
          check("con_pulses", c_con, e_pop.con);
          check("exec_start_pulses", c_es, e_pop.exec_start);
        end
        act = 1'b0;
      end
      if (pc_out && mar_in) begin
        act = 1'b1;
        c_cyc = 0; c_mrd = 0; c_inc = 0; c_ir = 0; c_ra = 0;
        c_lnk = 0; c_pld = 0; c_con = 0; c_es = 0;
      end
      if (act) begin
        c_cyc++;
        c_mrd += int'(mem_read); c_inc += int'(inc_pc); c_ir += int'(ir_in);
        c_ra += int'(ra_out); c_lnk += int'(link_in); c_pld += int'(pc_load);
        c_con += int'(con); c_es += int'(exec_start);
      end
      check("pc_ctrl_excl", 32'($countones({pc_load, con, inc_pc}) <= 1), 32'd1);
    end
  end

  // Wait for T0, load the instruction and queue what it should do
  task automatic do_instr(input logic [4:0] op, input logic [1:0] c2, input logic [18:0] imm,
                          input logic [31:0] bus, input int stall, input int delay);
    exp_t e;
    bit seen;
    bit tk;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clock);
      if (pc_out && mar_in && inc_pc) seen = 1'b1;
    end
    if (!seen) begin check("t0_timeout", 32'd0, 32'd1); return; end
    ir = {op, 4'd2, 2'b00, c2, imm};
    bus_in = bus; g_stall = stall; g_delay = delay;
    case (c2)
      2'b00:   tk = (bus == 32'd0);
      2'b01:   tk = (bus != 32'd0);
      2'b10:   tk = (bus[31] == 1'b0) && (bus != 32'd0);
      default: tk = (bus[31] == 1'b1);
    endcase
    e = '{default: 0};
    e.mem_rd = 1 + stall; e.inc_pc = 1; e.ir_in = 1;
    case (op)
      OP_NOP: e.cycles = 5;
      OP_BR:  begin e.ra_out = 1; e.con = int'(tk); e.cycles = tk ? 7 : 6; end
      OP_JR:  begin e.ra_out = 1; e.pc_load = 1; e.cycles = 6; end
      OP_JAL: begin e.ra_out = 1; e.pc_load = 1; e.link_in = 1; e.cycles = 7; end
      default: begin e.exec_start = 1; e.cycles = 6 + delay; end
    endcase
    e.cycles += stall;
    if (op != OP_HALT) begin sb.push_back(e); n_issued++; end
    #1 check("c_sext", c_sext, {{13{imm[18]}}, imm});
  endtask

  initial begin
    clear = 1'b1; run = 1'b1; ir = {OP_NOP, 27'd0}; bus_in = 32'd0; g_stall = 100;
    repeat (3) @(negedge clock);
    check("rst_outputs", 32'(all_o), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    clear = 1'b0;
    @(negedge clock);
    check("t0_after_rst", 32'({pc_out, mar_in, inc_pc, mem_read}), 32'hE);
    @(negedge clock);
    check("t1_strobes", 32'({mem_read, mdr_in, inc_pc}), 32'h6);
    #2 clear = 1'b1;
    #1 check("clr_mid_t1", 32'(all_o), 32'd0);
    check("clr_mid_t1_count", 32'(instr_count), 32'd0);
    repeat (2) @(negedge clock);
    g_stall = 0; clear = 1'b0;

    do_instr(OP_NOP, 2'b00, 19'h00000, 32'd0, 3, 0);
    do_instr(OP_BR,  2'b00, 19'h7FFFC, 32'd0, 0, 0);
    do_instr(OP_BR,  2'b00, 19'h7FFFC, 32'd5, 0, 0);
    do_instr(OP_BR,  2'b10, 19'h00010, 32'h8000_0000, 0, 0);
    do_instr(OP_BR,  2'b11, 19'h00010, 32'h8000_0000, 0, 0);
    do_instr(OP_BR,  2'b10, 19'h00020, 32'd0, 0, 0);
    do_instr(OP_BR,  2'b11, 19'h00020, 32'd0, 1, 0);
    do_instr(OP_BR,  2'b01, 19'h40001, 32'd7, 0, 0);
    do_instr(OP_BR,  2'b10, 19'h00003, 32'h0000_1234, 0, 0);
    do_instr(OP_JR,  2'b00, 19'h00005, 32'h0000_0100, 0, 0);
    do_instr(OP_ADD, 2'b00, 19'h40000, 32'd0, 1, 0);
    do_instr(OP_JAL, 2'b00, 19'h00000, 32'h0000_0200, 0, 0);
    do_instr(OP_HALT, 2'b00, 19'h00000, 32'd0, 0, 0);
    repeat (12) @(negedge clock);
    check("halted", 32'(halted), 32'd1);
    check("halt_not_counted", 32'(instr_count), 32'(CNTW'(n_issued)));
    check("sb_drained_at_halt", 32'(sb.size()), 32'd0);
    repeat (10) @(negedge clock);
    check("halted_sticky", 32'(all_o), 32'd1);

    clear = 1'b1;
    #1 check("clr_after_halt", 32'({halted, instr_count}), 32'd0);
    repeat (2) @(negedge clock);
    clear = 1'b0; n_issued = 0;
    for (int k = 0; k < (1 << CNTW); k++) do_instr(OP_NOP, 2'b00, 19'h0, 32'd0, 0, 0);
    do_instr(OP_ADD, 2'b01, 19'h00001, 32'd0, 0, 10);
    check("count_wrapped", 32'(instr_count), 32'd0);
    run = 1'b0;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clock);
    check("idle_outputs", 32'(all_o), 32'd0);
    check("final_count", 32'(instr_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Multi-cycle fetch/branch sequencer for the CPU's program counter. It runs the T0–T2 instruction fetch, decodes control-flow opcodes from the IR, evaluates branch conditions, and drives the PC's `enable` / `IncPC` / `CON` / `C_sign_extended` inputs. Non-control-flow instructions are handed to the execute controller through a start/done handshake. It sits between the PC, MAR/MDR, IR and the execute controller.

## Interface
Parameters:
- `OPW`, 5, opcode width (IR[31:27])
- `CNTW`, 16, retired-instruction counter width

Ports (clock and reset first):
- `clock` in 1: sole clock, rising edge
- `clear` in 1: reset, asynchronous, active-high
- `run` in 1: level; leaving IDLE requires `run`=1
- `mem_ready` in 1: memory read data valid in MDR this cycle
- `ir` in 32: instruction register contents
- `bus_in` in 32: datapath bus, valid while `ra_out`=1
- `exec_done` in 1: execute controller finished the current instruction
- `pc_out` out 1: PC drives bus
- `mar_in` out 1: MAR loads bus
- `inc_pc` out 1: to PC `IncPC`
- `mem_read` out 1: memory read strobe
- `mdr_in` out 1: MDR loads memory data
- `mdr_out` out 1: MDR drives bus
- `ir_in` out 1: IR loads bus
- `ra_out` out 1: R[IR[26:23]] drives bus
- `link_in` out 1: link register R8 loads bus
- `pc_load` out 1: to PC `enable` (loads `inputPC` from bus)
- `con` out 1: to PC `CON`
- `c_sext` out 32: to PC `C_sign_extended`, {{13{ir[18]}}, ir[18:0]}, always driven
- `exec_start` out 1: one-cycle start pulse to execute controller
- `halted` out 1: HALT reached
- `instr_count` out CNTW: retired instructions

## Operation
- Opcodes: `br`=5'h12, `jr`=5'h13, `jal`=5'h14, `nop`=5'h1A, `halt`=5'h1B; all others are execute-class.
- Branch condition C2=ir[20:19], tested on `bus_in`: 00 zero, 01 nonzero, 10 positive (bit31=0 and ≠0), 11 negative (bit31=1).
- States and Moore outputs (each strobe is 1 only in the listed state):
  - IDLE: none. Goes to T0 when `run`=1.
  - T0: `pc_out`, `mar_in`, `inc_pc`. Goes to T1.
  - T1: `mem_read`, `mdr_in`. Stays in T1 until `mem_ready`=1, then goes to T2.
  - T2: `mdr_out`, `ir_in`. Goes to DECODE.
  - DECODE: none. Dispatch: br→BR_EVAL; jr→JUMP; jal→LINK; nop→RETIRE; halt→HALT; other→EXEC.
  - BR_EVAL: `ra_out`; condition latched into `take_ff`. Goes to BR_TAKE if true, else RETIRE.
  - BR_TAKE: `con`. Goes to RETIRE.
  - LINK: `pc_out`, `link_in`. Goes to JUMP.
  - JUMP: `ra_out`, `pc_load`. Goes to RETIRE.
  - EXEC: `exec_start` in the first cycle only. Waits for `exec_done`, then goes to RETIRE.
  - RETIRE: `instr_count` += 1. Goes to T0 if `run`=1, else IDLE.
  - HALT: `halted`=1. Sticky until `clear`.
- Branch target is relative to the already-incremented PC: PC+1+C.
- At most one of `pc_load`, `con`, `inc_pc` is ever 1.
- `instr_count` wraps from 2^CNTW−1 to 0. `halt` is not counted.

## Timing
- Reset: state=IDLE, `take_ff`=0, `instr_count`=0, all strobes and `halted`=0, effective immediately on `clear`, asynchronous. Reset mid-fetch or mid-EXEC abandons the instruction; no strobe persists.
- Strobes are decoded from registered state only, so there are no input-to-output combinational paths except `c_sext`.
- Minimum cycles from entering T0 to next T0, with `mem_ready` in its first T1 cycle: nop 5, br not-taken 6, br taken 7, jr 6, jal 7, execute-class 6 + cycles waiting for `exec_done`.
- `exec_done` is sampled only in EXEC. Asserted in the same cycle as `exec_start`, it exits EXEC after one cycle.
- `run` is sampled only in IDLE and RETIRE; mid-instruction deassertion has no effect.

## Test plan
- Reset: hold `clear`, then `run`=1 → T0 strobes in the first cycle after release. Assert `clear` mid-T1 → all outputs 0 within that cycle, `instr_count`=0.
- Fetch stall: `mem_ready` low for 3 cycles in T1 → `mem_read`/`mdr_in` held 4 cycles, `ir_in` pulses once, `inc_pc` pulses exactly once.
- br C2=00 with `bus_in`=0 and ir[18:0]=19'h7FFFC → `con` for 1 cycle, `c_sext`=32'hFFFFFFFC. Same with `bus_in`=5 → no `con`, 6-cycle loop.
- brpl and brmi with `bus_in`=32'h80000000 → brmi taken, brpl not taken. `bus_in`=0 → both not taken.
- jal → LINK (`pc_out`+`link_in`) then JUMP (`ra_out`+`pc_load`), never `con`. Then halt → `halted`=1 sticky, `instr_count` unchanged by the halt.
- Preload via reset, count 2^16 nops → `instr_count` wraps to 0. An execute-class op with `exec_done` delayed 10 cycles → exactly one `exec_start` pulse.
